score_ctrl: RTL
===============

SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter UNIT_DIST, default 10: climbed pixels per score point; legal range 8..255.
REQ-002 Parameter SCORE_MAX, default 2047: saturation ceiling for score_num.
REQ-003 Clk  in  1  system clock, 50 MHz.
REQ-004 Reset_n  in  1  reset; asynchronous assert, active-low.
REQ-005 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-006 climb_px  in  10  pixels the world scrolled this frame; sampled on frame_tick.
REQ-007 show  in  3  game state; 3'd3 = game over, any other value = playing.
REQ-008 score_clr  in  1  synchronous clear for a new game.
REQ-009 score_num  out  11  current binary score.
REQ-010 digit3..digit0  out  4 each  BCD thousands..units of score_num, stable for the whole frame.
REQ-011 hi_num  out  11  best score since reset.
REQ-012 busy  out  1  high while an update sequence is in progress.
REQ-013 overrun  out  1  sticky; set when frame_tick arrives while busy.

Function
REQ-014 FSM states: IDLE, ACCUM, DIV, CONV, LATCH.
- IDLE->ACCUM on frame_tick.
- ACCUM->DIV after one cycle.
- DIV->CONV when dist_acc < UNIT_DIST.
- CONV->LATCH after exactly 11 shift cycles.
- LATCH->IDLE after one cycle.
REQ-015 ACCUM: dist_acc (12 bits) += climb_px if show != 3'd3, else += 0.
REQ-016 DIV, one step per cycle: dist_acc -= UNIT_DIST; score_num += 1, saturating at SCORE_MAX (subtraction still proceeds at saturation).
REQ-017 CONV: double-dabble of score_num into a 16-bit BCD shadow register, one bit per cycle, add-3 correction before each shift.
REQ-018 LATCH: copy the shadow register to digit3..digit0 in one cycle; digits SHALL NOT change in any other state.
REQ-019 Latency: frame_tick to updated digits = 1 + 1 + N + 11 + 1 cycles, where N = number of DIV subtractions.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 frame_tick while busy: the tick and its climb_px are dropped, and overrun is set.
REQ-022 score_clr has priority over all FSM activity; next cycle: FSM = IDLE, score_num = 0, dist_acc = 0, digits = 0, overrun = 0; hi_num is kept.
REQ-023 score_clr and frame_tick in the same cycle: the clear wins and the tick is dropped without setting overrun.
REQ-024 Game over (show == 3'd3): the FSM still runs, so digits refresh, but the score does not grow.

Reset
REQ-025 On Reset_n low, all outputs and internal registers SHALL be 0 and the FSM SHALL be IDLE, asynchronously, mid-sequence included.
REQ-026 Reset_n deassertion SHALL be synchronised to Clk inside the block before it is released to the registers.

Configuration
REQ-027 Macro SCORE_CTRL_HISCORE_EN defined:
- In LATCH, hi_num <= score_num whenever score_num > hi_num.
- hi_num survives score_clr.
REQ-028 Macro not defined: no high-score register is built and hi_num is tied to 11'd0.

Structure
REQ-029 Shared package doodle_pkg SHALL hold:
- the FSM state enum score_state_t;
- the constants SCORE_W = 11 and BCD_DIGITS = 4;
- the constant SHOW_GAMEOVER = 3'd3.
REQ-030 One sub-module, bin2bcd_seq, SHALL hold the sequential double-dabble with a start/done handshake; score_ctrl holds the FSM, accumulator and latches.

Verification
REQ-031 Reset, then 3 frames with climb_px = 25 and UNIT_DIST = 10:
- score_num = 2, 5, 7 after the respective frames;
- dist_acc remainder = 5, 0, 5.
REQ-032 score_num = 2040, then climb_px = 1000 -> score_num = 2047 and digits = 2,0,4,7.
REQ-033 frame_tick pulsed 5 cycles after a prior tick -> that tick is ignored, overrun = 1, and score reflects only the first tick.
REQ-034 show = 3'd3 with climb_px = 500 -> score_num unchanged, busy pulses, digits unchanged in value.
REQ-035 With SCORE_CTRL_HISCORE_EN: score 137, score_clr, then score 42 -> hi_num = 137 and score_num = 42.
REQ-036 Reset_n asserted while in CONV -> all outputs 0 immediately; first tick after release with climb_px = 30 -> digits = 0,0,0,3.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle score path: FSM state encoding,
// score/BCD widths and the BCD add-3 correction used by the converter.
package doodle_pkg;

  localparam int SCORE_W    = 11;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [2:0] SHOW_GAMEOVER = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DIV   = 3'd2,
    S_CONV  = 3'd3,
    S_LATCH = 3'd4
  } score_state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads the binary value, then one bit is
// shifted per cycle for SCORE_W cycles; done_o marks the final shift cycle.
module bin2bcd_seq
  import doodle_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  logic [SCORE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         cnt_q;

  assign bcd_adj = bcd_add3(bcd_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= 4'(SCORE_W);
    end else if (cnt_q != 4'd0) begin
      bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
      bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // High during the last shift so the caller leaves CONV after exactly SCORE_W cycles.
  assign done_o = (cnt_q == 4'd1);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_ctrl.sv
// Score controller: accumulates climbed pixels per frame, divides them into
// score points, converts to BCD and latches the digits once per frame.
// Optional high-score register enabled by SCORE_CTRL_HISCORE_EN.
module score_ctrl
  import doodle_pkg::*;
#(
  parameter int UNIT_DIST = 10,
  parameter int SCORE_MAX = 2047
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic [9:0]         climb_px,
  input  logic [2:0]         show,
  input  logic               score_clr,
  output logic [SCORE_W-1:0] score_num,
  output logic [3:0]         digit3,
  output logic [3:0]         digit2,
  output logic [3:0]         digit1,
  output logic [3:0]         digit0,
  output logic [SCORE_W-1:0] hi_num,
  output logic               busy,
  output logic               overrun
);

  localparam logic [11:0]        UNIT_W = 12'(UNIT_DIST);
  localparam logic [SCORE_W-1:0] SMAX   = SCORE_W'(SCORE_MAX);

  logic [1:0]         rst_sync_q;
  logic               rst_n_int;
  score_state_t       state_q, state_d;
  logic [11:0]        dist_q;
  logic [9:0]         climb_q;
  logic [SCORE_W-1:0] score_q;
  logic [BCD_W-1:0]   digits_q;
  logic               ovr_q;
  logic               bcd_start;
  logic               bcd_done;
  logic [BCD_W-1:0]   bcd_val;

  // Assert asynchronously, release two clocks after Reset_n rises.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (score_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (frame_tick) state_d = S_ACCUM;
        S_ACCUM: state_d = S_DIV;
        S_DIV:   if (dist_q < UNIT_W) state_d = S_CONV;
        S_CONV:  if (bcd_done) state_d = S_LATCH;
        S_LATCH: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    bcd_start = (state_q == S_DIV) && (dist_q < UNIT_W) && !score_clr;
  end

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      dist_q   <= '0;
      climb_q  <= '0;
      score_q  <= '0;
      digits_q <= '0;
      ovr_q    <= 1'b0;
    end else if (score_clr) begin
      dist_q   <= '0;
      climb_q  <= '0;
      score_q  <= '0;
      digits_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      // A tick outside IDLE is dropped along with its pixel count.
      if (frame_tick) begin
        if (state_q == S_IDLE) climb_q <= climb_px;
        else                   ovr_q   <= 1'b1;
      end
      case (state_q)
        S_ACCUM: if (show != SHOW_GAMEOVER) dist_q <= dist_q + {2'b00, climb_q};
        S_DIV: begin
          if (dist_q >= UNIT_W) begin
            dist_q  <= dist_q - UNIT_W;
            score_q <= (score_q < SMAX) ? score_q + 11'd1 : SMAX;
          end
        end
        S_LATCH: digits_q <= bcd_val;
        default: ;
      endcase
    end
  end

  bin2bcd_seq u_bcd (
    .clk_i   (Clk),
    .rst_ni  (rst_n_int),
    .clr_i   (score_clr),
    .start_i (bcd_start),
    .bin_i   (score_q),
    .done_o  (bcd_done),
    .bcd_o   (bcd_val)
  );

`ifdef SCORE_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hi_q;

  // Survives score_clr; only a full reset forgets the best score.
  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int)                                           hi_q <= '0;
    else if (!score_clr && state_q == S_LATCH && score_q > hi_q) hi_q <= score_q;
  end
  assign hi_num = hi_q;
`else
  assign hi_num = '0;
`endif

  assign score_num = score_q;
  assign digit3    = digits_q[15:12];
  assign digit2    = digits_q[11:8];
  assign digit1    = digits_q[7:4];
  assign digit0    = digits_q[3:0];
  assign overrun   = ovr_q;

endmodule
